mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between the instruction-fetch requester and the data requester (LWD/SWD) of the multicycle 16-bit CPU.
- Grants one access at a time, drives the memory handshake, returns read data and acks the owning requester.
- Enforces fetch starvation avoidance and a memory-response timeout with a sticky error flag.

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter giving the instruction-fetch and data requesters turns on one single-ported unified memory.
// Data wins ties. A waiting fetch is forced through after STARVE_LIMIT data grants, and a hung access aborts after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int WORD_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] d_rdata,
    output logic              ack_err,
    output logic              err_flag,
    output logic              busy,
    output logic              owner,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [TW-1:0]     tmo_cnt_r;
    logic [SW-1:0]     starve_cnt_r;
    logic              we_r;
    logic              i_ack_r;
    logic              d_ack_r;
    logic [WORD_W-1:0] i_rdata_r;
    logic [WORD_W-1:0] d_rdata_r;
    logic              ack_err_r;
    logic              err_flag_r;
    logic              busy_r;
    logic              owner_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [WORD_W-1:0] mem_wdata_r;

    logic              grant_valid_s;
    logic              grant_data_s;
    logic              grant_we_s;
    logic [WORD_W-1:0] resp_data_s;

    // Grant decision for the IDLE state: data first unless fetch has waited out its allowance
    always_comb begin
        grant_valid_s = 1'b0;
        grant_data_s  = 1'b0;
        if (i_req && d_req) begin
            grant_valid_s = 1'b1;
            grant_data_s  = (starve_cnt_r != SW'(STARVE_LIMIT));
        end else if (d_req) begin
            grant_valid_s = 1'b1;
            grant_data_s  = 1'b1;
        end else if (i_req) begin
            grant_valid_s = 1'b1;
            grant_data_s  = 1'b0;
        end else begin
            grant_valid_s = 1'b0;
            grant_data_s  = 1'b0;
        end
        grant_we_s  = grant_data_s & d_we;
        resp_data_s = we_r ? {WORD_W{1'b0}} : mem_rdata;
    end

    // Arbitration FSM with every output registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            tmo_cnt_r    <= {TW{1'b0}};
            starve_cnt_r <= {SW{1'b0}};
            we_r         <= 1'b0;
            i_ack_r      <= 1'b0;
            d_ack_r      <= 1'b0;
            i_rdata_r    <= {WORD_W{1'b0}};
            d_rdata_r    <= {WORD_W{1'b0}};
            ack_err_r    <= 1'b0;
            err_flag_r   <= 1'b0;
            busy_r       <= 1'b0;
            owner_r      <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_wdata_r  <= {WORD_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        state_r     <= ST_BUSY;
                        busy_r      <= 1'b1;
                        owner_r     <= grant_data_s;
                        we_r        <= grant_we_s;
                        mem_read_r  <= ~grant_we_s;
                        mem_write_r <= grant_we_s;
                        tmo_cnt_r   <= {TW{1'b0}};
                        if (grant_data_s) begin
                            mem_addr_r  <= d_addr;
                            mem_wdata_r <= d_wdata;
                            // Only data grants that overtook a waiting fetch count toward starvation
                            if (i_req && (starve_cnt_r != SW'(STARVE_LIMIT))) begin
                                starve_cnt_r <= starve_cnt_r + SW'(1);
                            end else begin
                                starve_cnt_r <= starve_cnt_r;
                            end
                        end else begin
                            mem_addr_r   <= i_addr;
                            starve_cnt_r <= {SW{1'b0}};
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        state_r     <= ST_RESP;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        ack_err_r   <= 1'b0;
                        if (owner_r) begin
                            d_ack_r   <= 1'b1;
                            d_rdata_r <= resp_data_s;
                        end else begin
                            i_ack_r   <= 1'b1;
                            i_rdata_r <= resp_data_s;
                        end
                    end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
                        state_r     <= ST_RESP;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        ack_err_r   <= 1'b1;
                        err_flag_r  <= 1'b1;
                        if (owner_r) begin
                            d_ack_r <= 1'b1;
                        end else begin
                            i_ack_r <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_RESP: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    i_ack_r   <= 1'b0;
                    d_ack_r   <= 1'b0;
                    i_rdata_r <= {WORD_W{1'b0}};
                    d_rdata_r <= {WORD_W{1'b0}};
                    ack_err_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    i_ack_r     <= 1'b0;
                    d_ack_r     <= 1'b0;
                    ack_err_r   <= 1'b0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign i_ack     = i_ack_r;
    assign i_rdata   = i_rdata_r;
    assign d_ack     = d_ack_r;
    assign d_rdata   = d_rdata_r;
    assign ack_err   = ack_err_r;
    assign err_flag  = err_flag_r;
    assign busy      = busy_r;
    assign owner     = owner_r;
    assign mem_addr  = mem_addr_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences, then random traffic
// against a transaction-level model with its own memory image and grant/starvation rules.
module tb_mem_port_arbiter;

    localparam int TIMEOUT      = 16;
    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = 16'h0000;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        ack_err;
    logic        err_flag;
    logic        busy;
    logic        owner;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int model_starve = 0;
    bit err_exp = 1'b0;
    logic [15:0] bench_mem [logic [15:0]];
    logic [15:0] model_mem [logic [15:0]];

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] ret;
        logic [15:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];
    bit   pat [6];

    mem_port_arbiter #(
        .WORD_W(16), .ADDR_W(16), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ack_err(ack_err), .err_flag(err_flag), .busy(busy), .owner(owner),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] bench_read(input logic [15:0] a);
        if (bench_mem.exists(a)) return bench_mem[a];
        return a ^ 16'h5AA5;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return a ^ 16'h5AA5;
    endfunction

    // Reference grant rule: ties go to data until fetch has been overtaken STARVE_LIMIT times
    function automatic bit model_grant(input bit pi, input bit pd);
        bit win_d;
        win_d = (pi && pd) ? (model_starve < STARVE_LIMIT) : pd;
        if (!win_d) model_starve = 0;
        else if (pi) model_starve = (model_starve < STARVE_LIMIT) ? model_starve + 1 : STARVE_LIMIT;
        return win_d;
    endfunction

    task automatic set_fetch(input logic [15:0] a);
        i_req  = 1'b1;
        i_addr = a;
    endtask

    task automatic set_data(input bit we, input logic [15:0] a, input logic [15:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
    endtask

    // Runs one granted access from an IDLE negedge with requests already driven; the bench acts as memory
    task automatic serve(input string tag, input bit exp_d, input bit exp_we,
                         input logic [15:0] exp_addr, input logic [15:0] exp_wdata, input int lat,
                         input bit use_mem, input logic [15:0] ret_data,
                         input logic [15:0] exp_rdata, input bit exp_err, input bit stray_resp);
        int cyc;
        int exp_cyc;
        bit done;
        bit bad_strobe;
        exp_cyc = (lat < TIMEOUT) ? lat + 1 : TIMEOUT;
        @(negedge clk);
        chk({tag, " busy"}, 32'(busy), 32'(1'b1));
        chk({tag, " owner"}, 32'(owner), 32'(exp_d));
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
        if (exp_we) chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(exp_wdata));
        cyc = 0;
        done = 1'b0;
        bad_strobe = 1'b0;
        while (!done && cyc < TIMEOUT + 4) begin
            if ({mem_read, mem_write} !== {~exp_we, exp_we}) bad_strobe = 1'b1;
            if (i_ack || d_ack) bad_strobe = 1'b1;
            if (cyc == lat) begin
                mem_ready = 1'b1;
                if (!use_mem) mem_rdata = ret_data;
                else if (mem_write) begin
                    bench_mem[mem_addr] = mem_wdata;
                    mem_rdata = 16'hFFFF;
                end else mem_rdata = bench_read(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'hDEAD;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            cyc++;
            if (i_ack || d_ack) done = 1'b1;
        end
        chk({tag, " strobes"}, 32'(bad_strobe), 32'(1'b0));
        chk({tag, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, " resp_flags"}, 32'({i_ack, d_ack, ack_err, busy, mem_read, mem_write}),
            32'({~exp_d, exp_d, exp_err, 1'b1, 1'b0, 1'b0}));
        chk({tag, " rdata"}, 32'(exp_d ? d_rdata : i_rdata), 32'(exp_rdata));
        chk({tag, " other_rdata"}, 32'(exp_d ? i_rdata : d_rdata), 32'(16'h0000));
        if (stray_resp) begin
            mem_ready = 1'b1;
            mem_rdata = 16'h1111;
        end
        if (exp_d) d_req = 1'b0;
        else i_req = 1'b0;
        err_exp = err_exp | exp_err;
        @(negedge clk);
        mem_ready = 1'b0;
        chk({tag, " idle_flags"}, 32'({busy, i_ack, d_ack, ack_err, mem_read, mem_write}), 32'(6'b0));
        chk({tag, " idle_rdata"}, {i_rdata, d_rdata}, 32'(0));
        chk({tag, " err_flag"}, 32'(err_flag), 32'(err_exp));
    endtask

    initial begin
        bit          win_d;
        bit          tmo;
        bit          we;
        int          lat;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] er;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1,  16'hA123, 16'hA123, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h5A5A, 0,  16'hFFFF, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 3,  16'h1234, 16'h1234, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 14, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 15, 16'h0F0F, 16'h0F0F, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 99, 16'h7777, 16'h0000, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 2,  16'h4321, 16'h4321, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 16'h0000, 16'hC0DE, 99, 16'h0000, 16'h0000, 1'b1};
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        @(negedge clk);
        chk("reset outputs", 32'({i_ack, d_ack, ack_err, err_flag, busy, owner, mem_read, mem_write}), 32'(0));
        chk("reset addr/wdata", {mem_addr, mem_wdata}, 32'(0));
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            if (vecs[k].is_d) set_data(vecs[k].we, vecs[k].addr, vecs[k].wdata);
            else set_fetch(vecs[k].addr);
            void'(model_grant(!vecs[k].is_d, vecs[k].is_d));
            serve($sformatf("vec%0d", k), vecs[k].is_d, vecs[k].we, vecs[k].addr, vecs[k].wdata,
                  vecs[k].lat, 1'b0, vecs[k].ret, vecs[k].exp_rdata, vecs[k].exp_err, 1'b0);
        end

        // Fetch held while data keeps re-requesting: D,D,D,I then the counter restarts
        for (int k = 0; k < 6; k++) begin
            if (!i_req) set_fetch(16'h0100);
            if (!d_req) set_data(1'b0, 16'h0400 + 16'(k), 16'h0000);
            void'(model_grant(i_req, d_req));
            a = pat[k] ? d_addr : i_addr;
            serve($sformatf("starve%0d", k), pat[k], 1'b0, a, 16'h0000, 0, 1'b1, 16'h0000,
                  model_read(a), 1'b0, 1'b0);
        end
        void'(model_grant(1'b1, 1'b0));
        serve("starve_drain", 1'b0, 1'b0, 16'h0100, 16'h0000, 1, 1'b1, 16'h0000,
              model_read(16'h0100), 1'b0, 1'b0);

        mem_ready = 1'b1;
        mem_rdata = 16'h2222;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("stray idle", 32'({busy, i_ack, d_ack, ack_err, mem_read, mem_write}), 32'(0));
        set_fetch(16'h0033);
        void'(model_grant(1'b1, 1'b0));
        serve("stray resp", 1'b0, 1'b0, 16'h0033, 16'h0000, 2, 1'b1, 16'h0000,
              model_read(16'h0033), 1'b0, 1'b1);

        set_data(1'b0, 16'h0777, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midop reset flags", 32'({i_ack, d_ack, ack_err, err_flag, busy, owner, mem_read, mem_write}), 32'(0));
        chk("midop reset addr", {mem_addr, mem_wdata}, 32'(0));
        d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        err_exp = 1'b0;
        model_starve = 0;
        set_fetch(16'h0042);
        void'(model_grant(1'b1, 1'b0));
        serve("after reset", 1'b0, 1'b0, 16'h0042, 16'h0000, 1, 1'b1, 16'h0000,
              model_read(16'h0042), 1'b0, 1'b0);

        for (int r = 0; r < 80; r++) begin
            if (!i_req && ($urandom_range(0, 2) != 0)) set_fetch(16'($urandom_range(0, 63)));
            if (!d_req && ($urandom_range(0, 2) != 0))
                set_data(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom));
            if (!i_req && !d_req) begin
                @(negedge clk);
                chk("rand idle", 32'(busy), 32'(1'b0));
                continue;
            end
            win_d = model_grant(i_req, d_req);
            lat = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 6);
            tmo = (lat >= TIMEOUT);
            we  = win_d ? d_we : 1'b0;
            a   = win_d ? d_addr : i_addr;
            wd  = d_wdata;
            er  = (we || tmo) ? 16'h0000 : model_read(a);
            serve($sformatf("rand%0d", r), win_d, we, a, wd, lat, 1'b1, 16'h0000, er, tmo, 1'b0);
            if (we && !tmo) model_mem[a] = wd;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
